// File: rtl/mdu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings and default latencies,
// used by the MDU, the controller and the hazard unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MUL_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT = 10;

    // Result computed at accept time, committed to HI/LO when the counter expires.
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_pend_t;

endpackage

// File: rtl/mdu_if.sv
// E-stage multiply/divide bundle between the datapath (master) and the MDU (slave).
interface mdu_if;
    import mdu_pkg::*;

    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  op;
    logic        start;
    logic [31:0] result;
    logic        busy;

    modport master (output src1, output src2, output op, output start,
                    input  result, input busy);
    modport slave  (input  src1, input  src2, input  op, input  start,
                    output result, output busy);

endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers; the result is computed
// at the accept edge and committed after a fixed busy window.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] MDU_src1,
    input  logic [31:0] MDU_src2,
    input  logic [3:0]  MDU_op,
    input  logic        MDU_start,
    output logic [31:0] E_MDU_result,
    output logic        E_MDU_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [CNT_W-1:0] cnt;
    mdu_pend_t        pend;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      div_src2;
    logic [31:0]      quo_s;
    logic [31:0]      rem_s;
    logic [31:0]      quo_u;
    logic [31:0]      rem_u;
    logic             div_zero;
    logic             div_ovf;
    logic             is_compute;
    logic [CNT_W-1:0] lat_next;
    mdu_pend_t        pend_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        div_zero = (MDU_src2 == 32'd0);
        div_ovf  = (MDU_src1 == 32'h8000_0000) && (MDU_src2 == 32'hFFFF_FFFF);
        // Dividing by one yields the defined overflow result and keeps zero out of the divider.
        div_src2 = (div_zero || div_ovf) ? 32'd1 : MDU_src2;

        prod_s = {{32{MDU_src1[31]}}, MDU_src1} * {{32{MDU_src2[31]}}, MDU_src2};
        prod_u = {32'd0, MDU_src1} * {32'd0, MDU_src2};
        quo_s  = $signed(MDU_src1) / $signed(div_src2);
        rem_s  = $signed(MDU_src1) % $signed(div_src2);
        quo_u  = MDU_src1 / div_src2;
        rem_u  = MDU_src1 % div_src2;

        is_compute = 1'b0;
        lat_next   = '0;
        pend_next  = '0;
        case (MDU_op)
            MDU_MULT: begin
                is_compute = 1'b1;
                lat_next   = CNT_W'(MUL_LAT);
                pend_next  = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
            end
            MDU_MULTU: begin
                is_compute = 1'b1;
                lat_next   = CNT_W'(MUL_LAT);
                pend_next  = '{wr: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
            end
            MDU_DIV: begin
                is_compute = 1'b1;
                lat_next   = CNT_W'(DIV_LAT);
                pend_next  = '{wr: !div_zero, hi: rem_s, lo: quo_s};
            end
            MDU_DIVU: begin
                is_compute = 1'b1;
                lat_next   = CNT_W'(DIV_LAT);
                pend_next  = '{wr: !div_zero, hi: rem_u, lo: quo_u};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            pend <= '0;
        end else if (cnt != '0) begin
            // Any start presented while counting, including on the commit edge, is dropped.
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1) && pend.wr) begin
                hi <= pend.hi;
                lo <= pend.lo;
            end
        end else if (MDU_start) begin
            if (is_compute) begin
                pend <= pend_next;
                cnt  <= lat_next;
            end else if (MDU_op == MDU_MTHI) begin
                hi <= MDU_src1;
            end else if (MDU_op == MDU_MTLO) begin
                lo <= MDU_src1;
            end
        end
    end

    assign E_MDU_busy = (cnt != '0);

    always_comb begin
        E_MDU_result = '0;
        case (MDU_op)
            MDU_MFHI: E_MDU_result = hi;
            MDU_MFLO: E_MDU_result = lo;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic HI/LO reference model,
// plus directed cases for signs, divide-by-zero, overflow, ignored starts and reset abort.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if bus ();

    mdu dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .MDU_src1     (bus.src1),
        .MDU_src2     (bus.src2),
        .MDU_op       (bus.op),
        .MDU_start    (bus.start),
        .E_MDU_result (bus.result),
        .E_MDU_busy   (bus.busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: plain 64-bit arithmetic on the operands.
    function automatic void model_compute(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            4'd2: begin pu = {32'd0, a} * {32'd0, b}; hi_m = pu[63:32]; lo_m = pu[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            default: ;
        endcase
    endfunction

    task automatic idle();
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.src1  = '0;
        bus.src2  = '0;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.op = MDU_MFHI;
        #1 h = bus.result;
        bus.op = MDU_MFLO;
        #1 l = bus.result;
        bus.op = MDU_NONE;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] h, l;
        read_hilo(h, l);
        check({tag, "_hi"}, h, hi_m);
        check({tag, "_lo"}, l, lo_m);
    endtask

    task automatic check_const(input string tag, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] h, l;
        read_hilo(h, l);
        check({tag, "_hi_const"}, h, eh);
        check({tag, "_lo_const"}, l, el);
    endtask

    // Issue a compute op; optionally present another start (or a reset) in busy cycle inj_cycle.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj_cycle, input logic [3:0] inj_op,
                       input logic [31:0] inj_a, input bit inj_rst);
        int n;
        int lat;
        lat = (op == MDU_MULT || op == MDU_MULTU) ? MUL_CYC : DIV_CYC;
        @(negedge clk);
        bus.op = op; bus.src1 = a; bus.src2 = b; bus.start = 1'b1;
        @(negedge clk);
        idle();
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == inj_cycle) begin
                if (inj_rst) reset_n = 1'b0;
                else begin
                    bus.op = inj_op; bus.src1 = inj_a; bus.src2 = inj_a; bus.start = 1'b1;
                end
            end
            @(negedge clk);
            idle();
            reset_n = 1'b1;
        end
        check("busy_len", 32'(n), 32'(inj_rst ? inj_cycle : lat));
        check("busy_after", 32'(bus.busy), 32'd0);
        if (inj_rst) begin hi_m = '0; lo_m = '0; end
        else model_compute(op, a, b);
        check_model("commit");
    endtask

    // One-cycle op (moves, reads, NONE, undefined codes) issued while idle.
    task automatic single_cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        @(negedge clk);
        bus.op = op; bus.src1 = a; bus.src2 = b; bus.start = 1'b1;
        exp_res = (op == MDU_MFHI) ? hi_m : (op == MDU_MFLO) ? lo_m : 32'd0;
        #1 check("result", bus.result, exp_res);
        @(negedge clk);
        idle();
        check("single_busy", 32'(bus.busy), 32'd0);
        if (op == MDU_MTHI) hi_m = a;
        if (op == MDU_MTLO) lo_m = a;
        check_model("single");
    endtask

    initial begin
        logic [3:0]  op, inj_op;
        logic [31:0] a, b;
        int          inj, lat;
        bit          rst;

        idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        #1 check("reset_result_none", bus.result, 32'd0);
        check_const("reset", 32'd0, 32'd0);

        run(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 0, 4'd0, 32'd0, 1'b0);
        check_const("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run(MDU_MULTU, 32'hFFFF_FFFD, 32'd5, 0, 4'd0, 32'd0, 1'b0);
        check_const("multu", 32'h0000_0004, 32'hFFFF_FFF1);
        run(MDU_DIVU, 32'd7, 32'd2, 0, 4'd0, 32'd0, 1'b0);
        check_const("divu", 32'd1, 32'd3);
        run(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 4'd0, 32'd0, 1'b0);
        check_const("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        single_cycle(MDU_MTHI, 32'h1234, 32'd0);
        single_cycle(MDU_MTLO, 32'h5678, 32'd0);
        run(MDU_DIV, 32'd55, 32'd0, 0, 4'd0, 32'd0, 1'b0);
        check_const("div_zero", 32'h1234, 32'h5678);

        run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd0, 32'd0, 1'b0);
        check_const("div_ovf", 32'd0, 32'h8000_0000);

        run(MDU_MULT, 32'd2, 32'd3, 2, MDU_MTLO, 32'hAAAA, 1'b0);
        check_const("mtlo_in_busy", 32'd0, 32'd6);

        run(MDU_DIVU, 32'd100, 32'd7, 4, 4'd0, 32'd0, 1'b1);
        check_const("reset_abort", 32'd0, 32'd0);
        repeat (DIV_CYC + 2) @(negedge clk);
        check("abort_no_busy", 32'(bus.busy), 32'd0);
        check_const("abort_no_commit", 32'd0, 32'd0);

        run(MDU_MULT, 32'h0001_0000, 32'h0003_0000, MUL_CYC, MDU_MULTU, 32'hFFFF_FFFF, 1'b0);
        check_const("commit_edge", 32'd3, 32'd0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 200);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if (op == MDU_DIV && $urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            if (op >= 4'd1 && op <= 4'd4) begin
                lat    = (op <= 4'd2) ? MUL_CYC : DIV_CYC;
                inj    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0;
                rst    = (inj != 0) && ($urandom_range(0, 7) == 0);
                inj_op = 4'($urandom_range(0, 15));
                run(op, a, b, inj, inj_op, $urandom, rst);
            end else begin
                single_cycle(op, a, b);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
